md_unit: RTL
============

# md_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the two source operands read from the register file and produces a result, destination index and one-cycle write-enable for the write-back port. It holds the pipeline via `busy` while it computes and issues a single write-back pulse on completion.

## Interface
- `DATA_WIDTH`, 32: operand/result width. Only 32 is supported; the counter is sized for it.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when idle.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  DATA_WIDTH  operand 1 (multiplicand/dividend).
- `rs2_data`  in  DATA_WIDTH  operand 2 (multiplier/divisor).
- `rd_addr`  in  5  destination register index.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse; drives write-back `wr_en`.
- `result`  out  DATA_WIDTH  result, valid while `done`=1 and held until the next accept.
- `rd_out`  out  5  latched `rd_addr`, valid with `done`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On `start`=1, latch `op`, both operands and `rd_addr`.
  - Go to CALC with iteration counter = 0, or go directly to DONE for a fast-path case.
- CALC: one iteration per clock. After the DATA_WIDTH-th iteration, register `result` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while `busy`=1 (CALC or DONE) is ignored. It is not queued.
- Multiply:
  - Form operand magnitudes using each operand's signedness. MUL/MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - Compute a 2*DATA_WIDTH-bit product by shift-add, one multiplier bit per cycle.
  - Negate the product if the operand signs differ.
  - MUL returns the low half; the other three ops return the high half.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed ops: quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
- Fast-path cases (IDLE goes directly to DONE, no CALC):
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- `flush`=1:
  - Next state is IDLE from any state.
  - `done` is not asserted, and a DONE-state pulse is cancelled that same cycle.
  - `flush` has priority over a simultaneous `start`.
- `rst_n` low at any time, including mid-CALC: state = IDLE, and `busy`, `done`, `result`, `rd_out` and all internal registers = 0 immediately.

## Timing
- Call the edge that accepts `start` edge 0.
- Iterative op: `busy`=1 from after edge 0. `done`=1 in the cycle after edge DATA_WIDTH+1, i.e. the 33rd cycle after accept. `busy`=0 after edge DATA_WIDTH+2.
- Fast path: `done`=1 in the cycle after edge 0, and IDLE after edge 1.
- `done` and `busy` are both high in the DONE cycle. The earliest next accept is the edge that leaves DONE+1 (IDLE).
- `result`/`rd_out` are registered with no combinational path from inputs, and stable from the DONE cycle until the next accept.

## Configuration
- `MD_FAST_MUL_EN` defined:
  - The four multiply ops use a single-cycle combinational signed/unsigned 33x33 multiply.
  - They take the fast path (`done` in the cycle after edge 0).
  - Division is unchanged.
- `MD_FAST_MUL_EN` undefined: all multiplies take the iterative DATA_WIDTH-cycle path.

## Test plan
- MUL 7 x 0xFFFFFFFD -> `result`=0xFFFFFFEB and `rd_out`=latched rd. `done` is exactly one cycle wide, at 33 cycles after accept (1 with `MD_FAST_MUL_EN`).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. All have `done` in the cycle after accept.
- Pulse `start` again at cycle 5 of a DIVU: it is ignored and exactly one `done` occurs. Assert `flush` at cycle 10 of another op: no `done`, `busy`=0 next cycle, and a new `start` is accepted the cycle after.
- Drop `rst_n` at cycle 15 of CALC: `busy`, `done`, `result`, `rd_out` = 0 without waiting for a clock edge. After release, a fresh MUL 3 x 4 gives 12.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit with a single write-back pulse.
// Define MD_FAST_MUL_EN for a single-cycle 33x33 multiply; division stays iterative.
module md_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rd_addr,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d, rneg_q, rneg_d;
  logic [2*W-1:0] a_q, a_d, acc_q, acc_d;
  logic [W-1:0]   b_q, b_d, result_q, result_d;
  logic [4:0]     rd_q, rd_d;

  logic           s1, s2, div_zero, ovf, ge;
  logic [W-1:0]   m1, m2, diff, q, r, fin;
  logic [2*W-1:0] p;

  // Operand signs already folded with each op's signedness
  assign s1       = rs1_data[W-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
  assign s2       = rs2_data[W-1] & (op[2] ? ~op[0] : ~op[1]);
  assign m1       = s1 ? -rs1_data : rs1_data;
  assign m2       = s2 ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  assign ovf      = ~op[0] & (rs1_data == {1'b1, {(W-1){1'b0}}}) & (&rs2_data);

  // Restoring step: shifted partial remainder is acc_q[2W-1:W-1]
  assign ge   = acc_q[2*W-1:W-1] >= {1'b0, a_q[W-1:0]};
  assign diff = acc_q[2*W-2:W-1] - a_q[W-1:0];

  assign p   = neg_q ? -acc_q : acc_q;
  assign q   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign r   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  assign fin = op_q[2] ? (op_q[1] ? r : q) : ((op_q[1:0] == 2'b00) ? p[W-1:0] : p[2*W-1:W]);

`ifdef MD_FAST_MUL_EN
  logic signed [W:0]     x1, x2;
  logic signed [2*W-1:0] fp;
  assign x1 = {s1, rs1_data};
  assign x2 = {s2, rs2_data};
  assign fp = (2*W)'(x1) * (2*W)'(x2);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        op_d   = op;
        rd_d   = rd_addr;
        neg_d  = s1 ^ s2;
        rneg_d = s1;
        cnt_d  = '0;
        if (op[2]) begin
          a_d     = {{W{1'b0}}, m2};
          acc_d   = {{W{1'b0}}, m1};
          state_d = CALC;
          if (div_zero) begin
            result_d = op[1] ? rs1_data : '1;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
            state_d  = DONE;
          end
        end else begin
`ifdef MD_FAST_MUL_EN
          result_d = (op[1:0] == 2'b00) ? fp[W-1:0] : fp[2*W-1:W];
          state_d  = DONE;
`else
          a_d     = {{W{1'b0}}, m1};
          b_d     = m2;
          acc_d   = '0;
          state_d = CALC;
`endif
        end
      end
    end else if (state_q == CALC) begin
      if (cnt_q == CW'(W)) begin
        result_d = fin;
        state_d  = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = ge ? {diff, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = acc_q + (b_q[0] ? a_q : '0);
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) && !flush;
  assign result = result_q;
  assign rd_out = rd_q;
endmodule
